// File: rtl/word_pkg.sv
// Shared definitions for the letter-array interface between word_builder and the word renderer.
package word_pkg;

    localparam int NUM_LETTERS = 10;
    localparam int CODE_WIDTH  = 6;
    localparam int LEN_W       = 4;

    typedef logic [CODE_WIDTH-1:0] letter_t;

    localparam letter_t BLANK_CODE = '0;

    typedef enum logic {
        EDIT,
        PENDING
    } state_t;

endpackage

// File: rtl/word_builder.sv
// Assembles a word from a valid/ready letter stream and publishes it to the
// display buffer only at a frame boundary, so the renderer never sees a half-edited word.
module word_builder
    import word_pkg::*;
(
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              char_valid_in,
    input  letter_t           char_in,
    output logic              char_ready_out,
    input  logic              backspace_in,
    input  logic              clear_in,
    input  logic              commit_in,
    input  logic              frame_start_in,
    output letter_t           word_out [NUM_LETTERS],
    output logic [LEN_W-1:0]  length_out,
    output logic              full_out,
    output logic              pending_out,
    output logic              commit_done_out
);

    if (NUM_LETTERS > 15 || NUM_LETTERS < 1) begin : g_bad_num_letters
        $error("word_builder: NUM_LETTERS must be in 1..15 to fit length_out");
    end

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    letter_t          work_q [NUM_LETTERS];
    letter_t          work_d [NUM_LETTERS];
    letter_t          disp_q [NUM_LETTERS];
    letter_t          disp_d [NUM_LETTERS];
    logic             done_q, done_d;

    assign full_out        = (len_q == LEN_W'(NUM_LETTERS));
    assign length_out      = len_q;
    assign pending_out     = (state_q == PENDING);
    assign commit_done_out = done_q;
    assign word_out        = disp_q;

    // A letter offered alongside clear or backspace is left for the source to hold.
    assign char_ready_out = (state_q == EDIT) && !full_out && !clear_in
                            && !backspace_in && !rst_in;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        len_d   = len_q;
        work_d  = work_q;
        disp_d  = disp_q;
        done_d  = 1'b0;

        unique case (state_q)
            EDIT: begin
                if (clear_in) begin
                    for (int i = 0; i < NUM_LETTERS; i++) work_d[i] = BLANK_CODE;
                    len_d = '0;
                end else if (backspace_in) begin
                    if (len_q != '0) begin
                        for (int i = 0; i < NUM_LETTERS; i++) begin
                            if (LEN_W'(i) == len_q - LEN_W'(1)) work_d[i] = BLANK_CODE;
                        end
                        len_d = len_q - LEN_W'(1);
                    end
                end else if (char_valid_in && char_ready_out) begin
                    for (int i = 0; i < NUM_LETTERS; i++) begin
                        if (LEN_W'(i) == len_q) work_d[i] = char_in;
                    end
                    len_d = len_q + LEN_W'(1);
                end
                // A frame_start in the commit cycle is deliberately ignored: latency is at least one frame.
                if (commit_in) state_d = PENDING;
            end
            PENDING: begin
                if (frame_start_in) begin
                    disp_d  = work_q;
                    state_d = EDIT;
                    done_d  = 1'b1;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (rst_in) begin
            state_q <= EDIT;
            len_q   <= '0;
            done_q  <= 1'b0;
            // NOTE: both buffers are reset because a blank word after reset is visible behaviour.
            for (int i = 0; i < NUM_LETTERS; i++) begin
                work_q[i] <= BLANK_CODE;
                disp_q[i] <= BLANK_CODE;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            done_q  <= done_d;
            work_q  <= work_d;
            disp_q  <= disp_d;
        end
    end

endmodule

// File: tb/tb_word_builder.sv
// Directed self-checking bench for word_builder: editing, conflicts, frame-aligned commit and reset.
module tb_word_builder;
    import word_pkg::*;

    logic             clk = 1'b0;
    logic             rst_in = 1'b1;
    logic             char_valid_in = 1'b0;
    letter_t          char_in = '0;
    logic             char_ready_out;
    logic             backspace_in = 1'b0;
    logic             clear_in = 1'b0;
    logic             commit_in = 1'b0;
    logic             frame_start_in = 1'b0;
    letter_t          word_out [NUM_LETTERS];
    logic [LEN_W-1:0] length_out;
    logic             full_out;
    logic             pending_out;
    logic             commit_done_out;

    int n_checks = 0;
    int n_bad    = 0;

    word_builder dut (
        .pixel_clk_in    (clk),
        .rst_in          (rst_in),
        .char_valid_in   (char_valid_in),
        .char_in         (char_in),
        .char_ready_out  (char_ready_out),
        .backspace_in    (backspace_in),
        .clear_in        (clear_in),
        .commit_in       (commit_in),
        .frame_start_in  (frame_start_in),
        .word_out        (word_out),
        .length_out      (length_out),
        .full_out        (full_out),
        .pending_out     (pending_out),
        .commit_done_out (commit_done_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_now();
        logic [63:0] w = '0;
        for (int i = 0; i < NUM_LETTERS; i++) w[i*CODE_WIDTH +: CODE_WIDTH] = word_out[i];
        return w;
    endfunction

    // Slots 0..n-1 hold first, first+1, ...; the rest are blank.
    function automatic logic [63:0] seq_word(input int n, input int first);
        logic [63:0] w = '0;
        for (int i = 0; i < n; i++) w[i*CODE_WIDTH +: CODE_WIDTH] = CODE_WIDTH'(first + i);
        return w;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int code);
        char_valid_in = 1'b1;
        char_in       = letter_t'(code);
        cycle();
        char_valid_in = 1'b0;
    endtask

    task automatic pulse_backspace();
        backspace_in = 1'b1;
        cycle();
        backspace_in = 1'b0;
    endtask

    task automatic publish();
        commit_in = 1'b1;
        cycle();
        commit_in = 1'b0;
        frame_start_in = 1'b1;
        cycle();
        frame_start_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        #1;
        check("ready_in_reset", char_ready_out, 0);
        cycle();
        cycle();
        rst_in = 1'b0;
        #1;
        check("rst_word", word_now(), 0);
        check("rst_len", length_out, 0);
        check("rst_ready", char_ready_out, 1);
        check("rst_pending", pending_out, 0);
        check("rst_done", commit_done_out, 0);

        // Fill to capacity, overflow offer is held
        for (int c = 1; c <= 10; c++) push(c);
        check("fill_len", length_out, 10);
        check("fill_full", full_out, 1);
        char_valid_in = 1'b1;
        char_in = 6'd11;
        #1;
        check("full_ready", char_ready_out, 0);
        cycle();
        check("full_len_held", length_out, 10);

        // Commit, frame_start five cycles later
        commit_in = 1'b1;
        cycle();
        commit_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("wait_pending", pending_out, 1);
            check("wait_word", word_now(), 0);
            cycle();
        end
        frame_start_in = 1'b1;
        #1;
        check("frame_word_old", word_now(), 0);
        check("frame_pending", pending_out, 1);
        cycle();
        frame_start_in = 1'b0;
        char_valid_in = 1'b0;
        check("pub_word", word_now(), seq_word(10, 1));
        check("pub_pending", pending_out, 0);
        check("pub_done", commit_done_out, 1);
        cycle();
        check("pub_done_once", commit_done_out, 0);

        // Backspace down to zero, no underflow
        clear_in = 1'b1;
        cycle();
        clear_in = 1'b0;
        check("clear_len", length_out, 0);
        push(5); push(6); push(7);
        check("bs_len3", length_out, 3);
        pulse_backspace();
        check("bs_len2", length_out, 2);
        pulse_backspace();
        check("bs_len1", length_out, 1);
        publish();
        check("bs_slots_blank", word_now(), seq_word(1, 5));
        pulse_backspace();
        check("bs_len0", length_out, 0);
        pulse_backspace();
        check("bs_underflow", length_out, 0);
        check("bs_not_full", full_out, 0);
        publish();
        check("bs_all_blank", word_now(), 0);

        // clear beats a same-cycle character
        push(1); push(2); push(3); push(4);
        check("pre_clear_len", length_out, 4);
        clear_in = 1'b1;
        char_valid_in = 1'b1;
        char_in = 6'd9;
        #1;
        check("clear_ready", char_ready_out, 0);
        cycle();
        clear_in = 1'b0;
        check("clear_conflict_len", length_out, 0);
        cycle();
        char_valid_in = 1'b0;
        check("held_char_taken", length_out, 1);

        // commit with frame_start in the same cycle waits a frame
        commit_in = 1'b1;
        frame_start_in = 1'b1;
        cycle();
        commit_in = 1'b0;
        frame_start_in = 1'b0;
        check("same_cyc_pending", pending_out, 1);
        check("same_cyc_done", commit_done_out, 0);
        cycle();
        check("same_cyc_word", word_now(), 0);
        frame_start_in = 1'b1;
        cycle();
        frame_start_in = 1'b0;
        check("next_frame_word", word_now(), seq_word(1, 9));
        check("next_frame_done", commit_done_out, 1);

        // Edits during PENDING are ignored
        push(3);
        check("pre_pend_len", length_out, 2);
        commit_in = 1'b1;
        cycle();
        commit_in = 1'b0;
        char_valid_in = 1'b1;
        char_in = 6'd20;
        #1;
        check("pend_ready", char_ready_out, 0);
        cycle();
        clear_in = 1'b1;
        cycle();
        clear_in = 1'b0;
        pulse_backspace();
        commit_in = 1'b1;
        cycle();
        commit_in = 1'b0;
        char_valid_in = 1'b0;
        check("pend_len", length_out, 2);
        frame_start_in = 1'b1;
        cycle();
        frame_start_in = 1'b0;
        check("pend_word", word_now(), seq_word(1, 9) | (64'd3 << CODE_WIDTH));
        check("pend_len_after", length_out, 2);
        cycle();
        frame_start_in = 1'b1;
        cycle();
        frame_start_in = 1'b0;
        check("no_queued_commit_pending", pending_out, 0);
        check("no_queued_commit_done", commit_done_out, 0);

        // Reset during PENDING drops the commit
        clear_in = 1'b1;
        cycle();
        clear_in = 1'b0;
        for (int c = 1; c <= 10; c++) push(c);
        publish();
        check("pre_rst_word", word_now(), seq_word(10, 1));
        commit_in = 1'b1;
        cycle();
        commit_in = 1'b0;
        check("pre_rst_pending", pending_out, 1);
        rst_in = 1'b1;
        #1;
        check("rst_ready_forced", char_ready_out, 0);
        cycle();
        rst_in = 1'b0;
        check("rst_pend_word", word_now(), 0);
        check("rst_pend_pending", pending_out, 0);
        check("rst_pend_len", length_out, 0);
        frame_start_in = 1'b1;
        cycle();
        frame_start_in = 1'b0;
        check("rst_no_done", commit_done_out, 0);
        check("rst_word_stays", word_now(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
